// File: rtl/serial_shift_pkg.sv
// Shared types and width helpers for the bit-serial shift sequencer.
package serial_shift_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;

  // Counter width that never collapses to zero bits.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;
  localparam int DEF_BIT_W = cw(DEF_WIDTH);
  localparam int DEF_DIV_W = cw(DEF_DIV);

endpackage

// File: rtl/serial_shift_ctrl_bit_timer.sv
// Modulo-DIV cycle counter; tc flags the last cycle of a period while enabled.
module bit_timer
  import serial_shift_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = cw(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/serial_shift_ctrl.sv
// Presents a parallel word MSB-first to a single-bit registered stage and
// captures the stage's q back into a parallel word.
module serial_shift_ctrl
  import serial_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             ser_data,
  output logic             ser_en,
  input  logic             q_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout
);

  localparam int BW = cw(WIDTH);
  localparam logic [BW-1:0] LASTBIT = BW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] tx, tx_n, rx, rx_n;
  logic [BW-1:0]    bitcnt;
  logic             cap_pend, accept, tmr_en, tc;

  // The timer runs one cycle ahead of the outputs: tc in cycle c means
  // cycle c+1 is a strobe cycle, so ser_en can be a plain register.
  assign tmr_en = accept || (state == SHIFT);

  bit_timer #(.DIV(DIV)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (!tmr_en),
    .en    (tmr_en),
    .tc    (tc)
  );

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE:    if (start) begin
                 state_n = SHIFT;
                 accept  = 1'b1;
               end
      SHIFT:   if (ser_en && bitcnt == LASTBIT) state_n = FLUSH;
      FLUSH:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    tx_n = tx;
    if (accept)                       tx_n = din;
    else if (state == SHIFT && ser_en) tx_n = {tx[WIDTH-2:0], 1'b0};

    // Capture trails each strobe by one cycle, giving the stage time to update q.
    rx_n = rx;
    if (accept)        rx_n = '0;
    else if (cap_pend) rx_n = {rx[WIDTH-2:0], q_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= '0;
      rx       <= '0;
      bitcnt   <= '0;
      cap_pend <= 1'b0;
      ser_data <= 1'b0;
      ser_en   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      rx       <= rx_n;
      cap_pend <= ser_en;
      if (accept)
        bitcnt <= '0;
      else if (state == SHIFT && ser_en)
        bitcnt <= bitcnt + 1'b1;
      ser_en   <= tc && (state_n == SHIFT);
      ser_data <= (state_n == SHIFT) && tx_n[WIDTH-1];
      busy     <= (state_n == SHIFT) || (state_n == FLUSH);
      done     <= (state_n == DONE);
      if (state == FLUSH)
        dout <= rx_n;
    end
  end

endmodule

// File: tb/tb_serial_shift_ctrl.sv
// Directed bench: two instances (DIV=4 and DIV=1) looped back through an enabled DFF.
module tb_serial_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stuck;
  logic [7:0] din;

  logic       q_in_a, ser_data_a, ser_en_a, busy_a, done_a, qa;
  logic [7:0] dout_a;
  logic       q_in_b, ser_data_b, ser_en_b, busy_b, done_b, qb;
  logic [7:0] dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_shift_ctrl #(.WIDTH(8), .DIV(4)) dut_a (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .ser_data(ser_data_a), .ser_en(ser_en_a), .q_in(q_in_a),
    .busy(busy_a), .done(done_a), .dout(dout_a)
  );

  serial_shift_ctrl #(.WIDTH(8), .DIV(1)) dut_b (
    .clk(clk), .reset(reset), .start(start), .din(din),
    .ser_data(ser_data_b), .ser_en(ser_en_b), .q_in(q_in_b),
    .busy(busy_b), .done(done_b), .dout(dout_b)
  );

  // Behavioral model of the enabled single-bit stage.
  always @(posedge clk) begin
    if (reset) begin
      qa <= 1'b0;
      qb <= 1'b0;
    end else begin
      if (ser_en_a) qa <= ser_data_a;
      if (ser_en_b) qb <= ser_data_b;
    end
  end

  assign q_in_a = stuck ? 1'b1 : qa;
  assign q_in_b = qb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       sel;
    logic [7:0] din;
    logic       stuck;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Start a transfer on the selected instance and score 40 cycles of outputs.
  task automatic run_xfer(input logic sel, input logic [7:0] d, input logic stk,
                          input logic [7:0] exp, input string tag);
    int dv, nbits, bad_en, bad_sd, bad_busy, done_cyc, done_cnt;
    logic [7:0] dout_at_done;
    dv = sel ? 1 : 4;
    nbits = 8 * dv;
    bad_en = 0; bad_sd = 0; bad_busy = 0; done_cyc = -1; done_cnt = 0;
    dout_at_done = '0;
    stuck = stk;
    din   = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      logic e_en, e_sd, e_busy, a_en, a_sd, a_busy, a_done;
      logic [7:0] a_dout;
      if (c == 5) din = ~d;
      a_en   = sel ? ser_en_b   : ser_en_a;
      a_sd   = sel ? ser_data_b : ser_data_a;
      a_busy = sel ? busy_b     : busy_a;
      a_done = sel ? done_b     : done_a;
      a_dout = sel ? dout_b     : dout_a;
      e_en   = (c <= nbits) && (c % dv == 0);
      e_sd   = (c <= nbits) ? d[7 - (c - 1) / dv] : 1'b0;
      e_busy = (c <= nbits + 1);
      if (a_en !== e_en)     bad_en++;
      if (a_sd !== e_sd)     bad_sd++;
      if (a_busy !== e_busy) bad_busy++;
      if (a_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
        dout_at_done = a_dout;
      end
      tick();
    end
    chk({tag, " ser_en pattern bad cycles"}, bad_en, 0);
    chk({tag, " ser_data pattern bad cycles"}, bad_sd, 0);
    chk({tag, " busy pattern bad cycles"}, bad_busy, 0);
    chk({tag, " done cycle"}, done_cyc, nbits + 2);
    chk({tag, " done pulse count"}, done_cnt, 1);
    chk({tag, " dout"}, dout_at_done, exp);
    stuck = 1'b0;
  endtask

  initial begin
    int rises[$];
    logic prev_busy;
    int n_done, n_busy;

    reset = 1'b1; start = 1'b0; din = '0; stuck = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    chk("reset busy_a", busy_a, 0);
    chk("reset done_a", done_a, 0);
    chk("reset ser_en_a/ser_data_a", {ser_en_a, ser_data_a}, 0);
    chk("reset dout_a", dout_a, 0);
    chk("reset outputs b", {busy_b, done_b, ser_en_b, ser_data_b, dout_b}, 0);

    vecs[0] = '{sel: 1'b0, din: 8'hA5, stuck: 1'b0, exp: 8'hA5};
    vecs[1] = '{sel: 1'b1, din: 8'h3C, stuck: 1'b0, exp: 8'h3C};
    vecs[2] = '{sel: 1'b0, din: 8'h00, stuck: 1'b1, exp: 8'hFF};
    vecs[3] = '{sel: 1'b0, din: 8'h81, stuck: 1'b0, exp: 8'h81};
    vecs[4] = '{sel: 1'b1, din: 8'hE7, stuck: 1'b0, exp: 8'hE7};
    vecs[5] = '{sel: 1'b0, din: 8'h5A, stuck: 1'b0, exp: 8'h5A};
    for (int i = 0; i < 6; i++)
      run_xfer(vecs[i].sel, vecs[i].din, vecs[i].stuck, vecs[i].exp,
               $sformatf("vec%0d", i));

    // start held high: accepts must be WIDTH*DIV+3 = 35 cycles apart
    din = 8'h96;
    start = 1'b1;
    prev_busy = busy_a;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy_a === 1'b1 && prev_busy === 1'b0) rises.push_back(i);
      prev_busy = busy_a;
    end
    start = 1'b0;
    chk("b2b accept count", rises.size(), 3);
    if (rises.size() >= 3) begin
      chk("b2b period 1", rises[1] - rises[0], 35);
      chk("b2b period 2", rises[2] - rises[1], 35);
    end
    for (int i = 0; i < 40; i++) tick();
    chk("b2b last dout", dout_a, 8'h96);

    // reset in cycle 17 aborts the transfer and clears dout
    din = 8'hA5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 17; c++) tick();
    chk("abort busy before reset", busy_a, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", busy_a, 0);
    chk("abort dout", dout_a, 0);
    chk("abort ser_en/ser_data/done", {ser_en_a, ser_data_a, done_a}, 0);
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 40; i++) begin
      if (done_a === 1'b1) n_done++;
      if (busy_a === 1'b1) n_busy++;
      tick();
    end
    chk("abort no done afterward", n_done, 0);
    chk("abort stays idle", n_busy, 0);

    // reset and start together: start dropped; next-cycle start accepted
    reset = 1'b1;
    start = 1'b1;
    din = 8'hC3;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("reset+start no transfer", busy_a, 0);
    run_xfer(1'b0, 8'hC3, 1'b0, 8'hC3, "after reset+start");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
